increment_term_stream_generator: RTL

//  Parametrised successor to the fixed 33-element K_n term calculator. Streams the

---
 rtl/increment_term_stream_generator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/increment_term_stream_generator.sv
// Streams comparator terms K_n = A0*(2n+1) -/+ C0 for n = 0..num_elements-1.
// C0 is fetched once per run from an external CORDIC unit via start/ready/ack,
// then the two accumulators advance by 2*A0 per accepted beat, saturating to
// the signed TW range.
module increment_term_stream_generator #(
    parameter int unsigned DW_INTEGER   = 18,
    parameter int unsigned DW_FRACTION  = 6,
    parameter int unsigned DW_INPUT     = 8,
    parameter int unsigned ANGLE_DW     = 8,
    parameter int unsigned MAX_ELEMENTS = 64,
    parameter int unsigned A0           = 1054,
    parameter int unsigned SCALE        = 8433,
    localparam int unsigned TW          = DW_INTEGER + DW_FRACTION + 1,
    localparam int unsigned CW          = $clog2(MAX_ELEMENTS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CW-1:0]       num_elements,
    input  logic [DW_INPUT-1:0] r_0,
    input  logic [ANGLE_DW-1:0] angle,
    output logic                cordic_start,
    output logic [TW-1:0]       cordic_x_scale,
    output logic [ANGLE_DW-1:0] cordic_angle,
    input  logic [TW-1:0]       cordic_result,
    input  logic                cordic_ready,
    output logic                cordic_ack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TW-1:0]       term_pos,
    output logic [TW-1:0]       term_neg,
    output logic [CW-1:0]       element_idx,
    output logic                last,
    output logic                sat,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {StIdle, StReq, StWaitC, StEmit, StDrain} state_e;

    localparam logic [TW:0] A0_EXT   = (TW + 1)'(A0);
    localparam logic [TW:0] A0X2_EXT = (TW + 1)'(2 * A0);

    state_e              r_state;
    logic                r_cordic_start;
    logic                r_cordic_ack;
    logic [TW-1:0]       r_x_scale;
    logic [ANGLE_DW-1:0] r_angle;
    logic [CW-1:0]       r_num;
    logic                r_out_valid;
    logic [TW-1:0]       r_pos;
    logic [TW-1:0]       r_neg;
    logic [CW-1:0]       r_idx;
    logic                r_last;
    logic                r_sat;
    logic                r_done;

    logic                w_n_valid;
    logic [TW-1:0]       w_x_scale;
    logic [TW:0]         w_c0_ext;
    logic [TW:0]         w_load_pos;
    logic [TW:0]         w_load_neg;
    logic [TW:0]         w_step_pos;
    logic [TW:0]         w_step_neg;

    // Clamp a TW+1 bit sum into signed TW range; returns {saturated, value}.
    function automatic logic [TW:0] f_clamp(input logic [TW:0] s);
        if (s[TW] != s[TW-1]) begin
            f_clamp = {1'b1, s[TW], {(TW - 1){~s[TW]}}};
        end else begin
            f_clamp = {1'b0, s[TW-1:0]};
        end
    endfunction

    assign w_n_valid  = (num_elements != '0) && (num_elements <= CW'(MAX_ELEMENTS));
    // Product taken modulo 2^TW, i.e. truncated to the TW LSBs.
    assign w_x_scale  = TW'(r_0) * TW'(SCALE);
    assign w_c0_ext   = {cordic_result[TW-1], cordic_result};
    assign w_load_pos = f_clamp(A0_EXT - w_c0_ext);
    assign w_load_neg = f_clamp(A0_EXT + w_c0_ext);
    assign w_step_pos = f_clamp({r_pos[TW-1], r_pos} + A0X2_EXT);
    assign w_step_neg = f_clamp({r_neg[TW-1], r_neg} + A0X2_EXT);

    // Run sequencing, CORDIC handshake and term accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_cordic_start <= 1'b0;
            r_cordic_ack   <= 1'b0;
            r_x_scale      <= '0;
            r_angle        <= '0;
            r_num          <= '0;
            r_out_valid    <= 1'b0;
            r_pos          <= '0;
            r_neg          <= '0;
            r_idx          <= '0;
            r_last         <= 1'b0;
            r_sat          <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_cordic_start <= 1'b0;
            r_cordic_ack   <= 1'b0;
            r_done         <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        if (w_n_valid) begin
                            r_num          <= num_elements;
                            r_angle        <= angle;
                            r_x_scale      <= w_x_scale;
                            r_cordic_start <= 1'b1;
                            r_state        <= StReq;
                        end else begin
                            // Empty or oversized run: finish without touching CORDIC.
                            r_done <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (abort) begin
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_state <= StWaitC;
                    end
                end
                StWaitC: begin
                    if (abort) begin
                        // CORDIC result is still owed; it must be acked in DRAIN.
                        r_state <= StDrain;
                    end else if (cordic_ready) begin
                        r_cordic_ack <= 1'b1;
                        r_pos        <= w_load_pos[TW-1:0];
                        r_neg        <= w_load_neg[TW-1:0];
                        r_sat        <= w_load_pos[TW] | w_load_neg[TW];
                        r_idx        <= '0;
                        r_last       <= (r_num == CW'(1));
                        r_out_valid  <= 1'b1;
                        r_state      <= StEmit;
                    end
                end
                StEmit: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= StIdle;
                    end else if (out_ready) begin
                        if (r_last) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= StIdle;
                        end else begin
                            r_pos  <= w_step_pos[TW-1:0];
                            r_neg  <= w_step_neg[TW-1:0];
                            r_sat  <= w_step_pos[TW] | w_step_neg[TW];
                            r_idx  <= r_idx + CW'(1);
                            r_last <= ((r_idx + CW'(2)) == r_num);
                        end
                    end
                end
                StDrain: begin
                    if (cordic_ready) begin
                        r_cordic_ack <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cordic_start   = r_cordic_start;
    assign cordic_x_scale = r_x_scale;
    assign cordic_angle   = r_angle;
    assign cordic_ack     = r_cordic_ack;
    assign out_valid      = r_out_valid;
    assign term_pos       = r_pos;
    assign term_neg       = r_neg;
    assign element_idx    = r_idx;
    assign last           = r_last;
    assign sat            = r_sat;
    assign busy           = (r_state != StIdle);
    assign done           = r_done;

endmodule
